pool_stream_unit: RTL

Streaming, parametrised successor to the combinational pooling window. Accepts one signed Q4.11 element per cycle over a valid/ready handshake, reduces each group of WIN elements by average or max (selected per window), and presents one result per window through a one-entry output register. Sits between the convolution output stream and the next layer's input buffer in the CNN datapath.

---
 rtl/pool_pkg.sv | 18 +
 rtl/pool_reduce_alu.sv | 21 ++
 rtl/pool_stream_unit.sv | 107 ++++++++++
 3 files changed

// File: rtl/pool_pkg.sv
// Shared types and constants for the streaming pooling unit.
// Elements are Q4.11; the arithmetic itself does not depend on the format.
package pool_pkg;

  localparam int DEFAULT_DATA_W = 16;
  localparam int FRAC_W         = 11;

  typedef enum logic {
    POOL_AVG = 1'b0,
    POOL_MAX = 1'b1
  } pool_mode_e;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } pool_state_e;

endpackage

// File: rtl/pool_reduce_alu.sv
// One reduction step of a pooling window: running sum or running signed
// maximum.
module pool_reduce_alu
  import pool_pkg::*;
#(
  parameter int ACC_W = 18
) (
  input  logic signed [ACC_W-1:0] acc,
  input  logic signed [ACC_W-1:0] elem,
  input  pool_mode_e              mode,
  output logic signed [ACC_W-1:0] acc_next
);

  always_comb begin
    acc_next = acc + elem;
    if (mode == POOL_MAX) begin
      acc_next = (elem > acc) ? elem : acc;
    end
  end

endmodule

// File: rtl/pool_stream_unit.sv
// Streaming pooling unit: reduces each group of WIN signed elements to one
// average or max result, held in a single output register.
module pool_stream_unit
  import pool_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int WIN    = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     mode,
  input  logic                     clear,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     out_mode
);

  localparam int CNT_W  = $clog2(WIN);
  localparam int ACC_W  = DATA_W + CNT_W;
  // WIN == 1 gives a zero-width count; keep at least one bit of storage
  localparam int CNT_RW = (CNT_W < 1) ? 1 : CNT_W;

  pool_state_e              state, state_next;
  logic        [CNT_RW-1:0] cnt;
  logic signed [ACC_W-1:0]  acc, acc_next, alu_acc, elem_sext;
  pool_mode_e               mode_r, win_mode;
  logic                     accept, last;

  function automatic logic signed [DATA_W-1:0] pool_result(
    input logic signed [ACC_W-1:0] a,
    input pool_mode_e              m
  );
    logic signed [ACC_W-1:0] shifted;
    shifted = a >>> CNT_W;
    return (m == POOL_AVG) ? shifted[DATA_W-1:0] : a[DATA_W-1:0];
  endfunction

  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign elem_sext = ACC_W'(in_data);
  assign last      = (cnt == CNT_RW'(WIN - 1));
  // The first element of a window both seeds the accumulator and picks the mode
  assign win_mode  = (state == IDLE) ? pool_mode_e'(mode) : mode_r;
  assign acc_next  = (state == IDLE) ? elem_sext : alu_acc;

  pool_reduce_alu #(
    .ACC_W(ACC_W)
  ) u_alu (
    .acc     (acc),
    .elem    (elem_sext),
    .mode    (mode_r),
    .acc_next(alu_acc)
  );

  always_comb begin
    state_next = state;
    if (clear) begin
      state_next = IDLE;
    end else if (accept) begin
      state_next = last ? IDLE : ACCUM;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      acc       <= '0;
      mode_r    <= POOL_AVG;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_mode  <= 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (clear) begin
        cnt <= '0;
      end else if (accept) begin
        acc <= acc_next;
        if (state == IDLE) begin
          mode_r <= win_mode;
        end
        if (last) begin
          cnt       <= '0;
          out_data  <= pool_result(acc_next, win_mode);
          out_mode  <= win_mode;
          out_valid <= 1'b1;
        end else begin
          cnt <= cnt + CNT_RW'(1);
        end
      end
    end
  end

endmodule
